skid_fifo: RTL and testbench

// - Elastic FIFO stage directly downstream of the skid controller: consumes its out_valid/out_data stream, returns in_ready as its out_ready.
// - Absorbs bursts and decouples producer from a slow consumer; first-word-fall-through output with the same valid/ready protocol.
// - in_ready depends only on registered state, so there is no combinational ready path back into the skid stage.

---
 rtl/skid_pkg.sv | 16 +
 rtl/skid_fifo_mem.sv | 34 +++
 rtl/skid_fifo.sv | 95 +++++++++
 tb/tb_skid_fifo.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared constants and the handshake-op encoding for the skid stage and its elastic FIFO.
package skid_pkg;

    localparam int SKID_DATA_W_DEFAULT     = 32;
    localparam int SKID_FIFO_DEPTH_DEFAULT = 4;
    localparam int SKID_STAT_W             = 32;

    // Encoded as {push, pop}, so it can be cast directly from the two handshake bits.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/skid_fifo_mem.sv
// DEPTH x DATA_W register array for skid_fifo: one write port, one asynchronous read port.
module skid_fifo_mem
    import skid_pkg::*;
#(
    parameter int DATA_W = SKID_DATA_W_DEFAULT,
    parameter int DEPTH  = SKID_FIFO_DEPTH_DEFAULT,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is reset because the FWFT head is visible on out_data even
    // when empty; clearing it keeps out_data at 0 after reset instead of X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/skid_fifo.sv
// Elastic first-word-fall-through FIFO behind the skid stage; ready/valid decoded from registered level only.
// Optional statistics (high_water, stall_cnt) are enabled by defining SKID_FIFO_STATS_EN.
module skid_fifo
    import skid_pkg::*;
#(
    parameter int DATA_W    = SKID_DATA_W_DEFAULT,
    parameter int DEPTH     = SKID_FIFO_DEPTH_DEFAULT,
    parameter int AF_THRESH = DEPTH - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] level,
`ifdef SKID_FIFO_STATS_EN
    output logic [$clog2(DEPTH):0] high_water,
    output logic [SKID_STAT_W-1:0] stall_cnt,
`endif
    output logic                   almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    fifo_op_e         op;

    // Full blocks pushes even when a pop happens in the same cycle; this keeps in_ready free
    // of any combinational path from out_ready.
    assign in_ready    = (level != FULL_LVL);
    assign out_valid   = (level != '0);
    assign almost_full = (level >= AF_LVL);
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign op          = fifo_op_e'({push, pop});

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case (op)
                OP_PUSH: level <= level + 1'b1;
                OP_POP:  level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    skid_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push && !flush),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

`ifdef SKID_FIFO_STATS_EN
    // Statistics survive flush; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_water <= '0;
            stall_cnt  <= '0;
        end else begin
            if (level > high_water) high_water <= level;
            if (in_valid && !in_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_skid_fifo.sv
// Directed self-checking bench for skid_fifo (DEPTH=4, AF_THRESH=3); stats checks when SKID_FIFO_STATS_EN is defined.
module tb_skid_fifo;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        level;
    logic              almost_full;
`ifdef SKID_FIFO_STATS_EN
    logic [2:0]        high_water;
    logic [31:0]       stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];

    skid_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AF_THRESH (DEPTH - 1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
`ifdef SKID_FIFO_STATS_EN
        .high_water  (high_water),
        .stall_cnt   (stall_cnt),
`endif
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " level"},       64'(level),       64'd0);
        check({tag, " in_ready"},    64'(in_ready),    64'd1);
        check({tag, " out_valid"},   64'(out_valid),   64'd0);
        check({tag, " out_data"},    64'(out_data),    64'd0);
        check({tag, " almost_full"}, 64'(almost_full), 64'd0);
`ifdef SKID_FIFO_STATS_EN
        check({tag, " high_water"},  64'(high_water),  64'd0);
        check({tag, " stall_cnt"},   64'(stall_cnt),   64'd0);
`endif
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step();

        // Three back-to-back pushes with the consumer stalled.
        in_valid = 1'b1;
        in_data  = 32'hA1;
        step();
        check("push1 out_valid", 64'(out_valid), 64'd1);
        check("push1 out_data",  64'(out_data),  64'hA1);
        in_data = 32'hA2;
        step();
        in_data = 32'hA3;
        step();
        in_valid = 1'b0;
        check("burst level",       64'(level),       64'd3);
        check("burst almost_full", 64'(almost_full), 64'd1);
        check("burst out_data",    64'(out_data),    64'hA1);

        // Fill to DEPTH, then a single pop while upstream keeps offering A5.
        in_valid = 1'b1;
        in_data  = 32'hA4;
        step();
        check("full level",    64'(level),    64'd4);
        check("full in_ready", 64'(in_ready), 64'd0);
        in_data   = 32'hA5;
        out_ready = 1'b1;
        #1;
        check("pop while full in_ready same cycle", 64'(in_ready), 64'd0);
        check("pop while full head",                64'(out_data), 64'hA1);
        step();
        out_ready = 1'b0;
        check("after pop level",    64'(level),    64'd3);
        check("after pop in_ready", 64'(in_ready), 64'd1);
        check("after pop head",     64'(out_data), 64'hA2);
        step();
        in_valid = 1'b0;
        check("refill level", 64'(level), 64'd4);

        // Drain two entries to reach level 2 (A4, A5 remain).
        out_ready = 1'b1;
        step();
        check("drain head A3", 64'(out_data), 64'hA3);
        step();
        check("drain level", 64'(level), 64'd2);
        exp_q = '{32'hA4, 32'hA5};

        // Steady-state push+pop at level 2; pointers wrap several times.
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 32'hB0 + 32'(i);
            #1;
            check($sformatf("stream head %0d", i), 64'(out_data), 64'(exp_q[0]));
            exp_q.push_back(in_data);
            void'(exp_q.pop_front());
            step();
            check($sformatf("stream level %0d", i), 64'(level), 64'd2);
        end
        in_valid = 1'b0;
        check("stream tail0", 64'(out_data), 64'hC2);
        step();
        check("stream tail1", 64'(out_data), 64'hC3);
        step();
        out_ready = 1'b0;
        check("stream empty level",     64'(level),     64'd0);
        check("stream empty out_valid", 64'(out_valid), 64'd0);

        // Push into empty FIFO: visible exactly one cycle later.
        in_valid = 1'b1;
        in_data  = 32'h55;
        #1;
        check("empty push same cycle out_valid", 64'(out_valid), 64'd0);
        in_data = 32'h55;
        step();
        check("empty push out_valid", 64'(out_valid), 64'd1);
        check("empty push out_data",  64'(out_data),  64'h55);
        in_data = 32'h66;
        step();
        in_data = 32'h77;
        step();
        check("pre-flush level", 64'(level), 64'd3);

        // Flush together with push and pop.
        flush     = 1'b1;
        in_data   = 32'h88;
        out_ready = 1'b1;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush level",       64'(level),       64'd0);
        check("flush out_valid",   64'(out_valid),   64'd0);
        check("flush in_ready",    64'(in_ready),    64'd1);
        check("flush almost_full", 64'(almost_full), 64'd0);
`ifdef SKID_FIFO_STATS_EN
        check("flush keeps high_water", 64'(high_water), 64'd4);
        check("flush keeps stall_cnt",  64'(stall_cnt),  64'd1);
`endif
        in_valid = 1'b1;
        in_data  = 32'h99;
        step();
        in_valid = 1'b0;
        check("post-flush out_data", 64'(out_data), 64'h99);
        check("post-flush level",    64'(level),    64'd1);

        // Asynchronous reset mid-operation, away from any clock edge.
        in_valid = 1'b1;
        in_data  = 32'hAB;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async rst");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();

`ifdef SKID_FIFO_STATS_EN
        // Ten cycles of offered data with the consumer stalled: 4 accepted, 6 stalled.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hC0 + 32'(i);
            step();
        end
        check("stats level",      64'(level),      64'd4);
        check("stats high_water", 64'(high_water), 64'd4);
        check("stats stall_cnt",  64'(stall_cnt),  64'd6);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("stats rst");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
